// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: write port, two read ports, the
// reservation request and the scoreboard status outputs.
interface regfile_mp_sb_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
);
   logic [WIDTH-1:0] data_in;
   logic [AW-1:0]    writenum;
   logic             write;
   logic [AW-1:0]    readnum_a;
   logic [AW-1:0]    readnum_b;
   logic [WIDTH-1:0] data_out_a;
   logic [WIDTH-1:0] data_out_b;
   logic             busy_a;
   logic             busy_b;
   logic             reserve;
   logic [AW-1:0]    reservenum;
   logic             reserve_ok;
   logic [DEPTH-1:0] busy_vec;
   logic [AW:0]      busy_cnt;

   // Controller/datapath side.
   modport master (
      output data_in, writenum, write, readnum_a, readnum_b, reserve, reservenum,
      input  data_out_a, data_out_b, busy_a, busy_b, reserve_ok, busy_vec, busy_cnt
   );

   // Register file side.
   modport slave (
      input  data_in, writenum, write, readnum_a, readnum_b, reserve, reservenum,
      output data_out_a, data_out_b, busy_a, busy_b, reserve_ok, busy_vec, busy_cnt
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Register file (WIDTH x DEPTH) with two combinational read ports, one
// synchronous write port and a per-register busy scoreboard.
//
// Reservation handshake: reserve is the request (valid), reserve_ok is the
// combinational acceptance (ready). A reservation takes effect at the rising
// edge where both are high; while reserve_ok is low the requester holds
// reserve and reservenum stable and retries on following cycles.
module regfile_mp_sb #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
) (
   input logic            clk,
   input logic            reset,
   regfile_mp_sb_if.slave bus
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [AW:0]      cnt;

   logic             wr_valid;
   logic             rs_valid;
   logic             rs_ok;
   logic [DEPTH-1:0] wr_sel;
   logic [DEPTH-1:0] rs_hit;
   logic [DEPTH-1:0] rs_sel;
   logic             wr_busy;
   logic             rs_busy;
   logic             cnt_inc;
   logic             cnt_dec;
   logic [WIDTH-1:0] raw_a;
   logic [WIDTH-1:0] raw_b;
   logic             raw_busy_a;
   logic             raw_busy_b;

   function automatic logic in_range(input logic [AW-1:0] n);
      return {1'b0, n} < DEPTH_W;
   endfunction

   function automatic logic masked_r0(input logic [AW-1:0] n);
      return ZERO_R0 && (n == '0);
   endfunction

   // Decode write and reserve requests, and decide whether the reserve is accepted.
   always_comb begin
      wr_valid = bus.write && in_range(bus.writenum) && !masked_r0(bus.writenum);
      rs_valid = bus.reserve && in_range(bus.reservenum) && !masked_r0(bus.reservenum);
      wr_sel   = '0;
      rs_hit   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_sel[i] = wr_valid && (bus.writenum == AW'(i));
         rs_hit[i] = rs_valid && (bus.reservenum == AW'(i));
      end
      wr_busy = |(busy & wr_sel);
      rs_busy = |(busy & rs_hit);
      // A busy register may be re-reserved in the same cycle its writeback lands.
      rs_ok   = rs_valid && (!rs_busy || (wr_valid && (bus.writenum == bus.reservenum)));
      rs_sel  = rs_ok ? rs_hit : '0;
      // Count follows popcount: +1 only when a clear bit gets set, -1 only when a
      // set bit is cleared and not set again by a same-cycle reserve.
      cnt_inc = rs_ok && !rs_busy;
      cnt_dec = wr_valid && wr_busy && !(rs_ok && (bus.writenum == bus.reservenum));
   end

   // Read muxes with out-of-range / R0 masking, then write-to-read bypass.
   always_comb begin
      raw_a      = '0;
      raw_b      = '0;
      raw_busy_a = 1'b0;
      raw_busy_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!(ZERO_R0 && (i == 0))) begin
            if (bus.readnum_a == AW'(i)) begin
               raw_a      = regs[i];
               raw_busy_a = busy[i];
            end
            if (bus.readnum_b == AW'(i)) begin
               raw_b      = regs[i];
               raw_busy_b = busy[i];
            end
         end
      end
      bus.data_out_a = raw_a;
      bus.busy_a     = raw_busy_a;
      bus.data_out_b = raw_b;
      bus.busy_b     = raw_busy_b;
      if (BYPASS && wr_valid && (bus.writenum == bus.readnum_a)) begin
         bus.data_out_a = bus.data_in;
         bus.busy_a     = 1'b0;
      end
      if (BYPASS && wr_valid && (bus.writenum == bus.readnum_b)) begin
         bus.data_out_b = bus.data_in;
         bus.busy_b     = 1'b0;
      end
      bus.reserve_ok = rs_ok;
      bus.busy_vec   = busy;
      bus.busy_cnt   = cnt;
   end

   // Register storage, scoreboard bits and busy count; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
         cnt  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) regs[i] <= bus.data_in;
         end
         // Reserve is applied after the write clear so it wins on the same register.
         busy <= (busy & ~wr_sel) | rs_sel;
         if (cnt_inc && !cnt_dec)      cnt <= cnt + (AW+1)'(1);
         else if (cnt_dec && !cnt_inc) cnt <= cnt - (AW+1)'(1);
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a vector table on the default build
// plus hand sequences for reset, no-bypass/zero-R0 and a DEPTH=6 build.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_mp_sb_if #(.WIDTH(16), .DEPTH(8), .AW(3)) if0 ();
   regfile_mp_sb_if #(.WIDTH(16), .DEPTH(8), .AW(3)) if1 ();
   regfile_mp_sb_if #(.WIDTH(16), .DEPTH(6), .AW(3)) if2 ();

   regfile_mp_sb #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1'b1), .ZERO_R0(1'b0))
      dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   regfile_mp_sb #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1'b0), .ZERO_R0(1'b1))
      dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
   regfile_mp_sb #(.WIDTH(16), .DEPTH(6), .AW(3), .BYPASS(1'b1), .ZERO_R0(1'b0))
      dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

   typedef struct {
      logic        write;
      logic [2:0]  wnum;
      logic [15:0] din;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        reserve;
      logic [2:0]  rnum;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      logic        exp_ba;
      logic        exp_bb;
      logic        exp_ok;
      logic [7:0]  exp_vec;
      logic [3:0]  exp_cnt;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // Clock/reset block: everything idle, reset asserted from time 0.
      reset = 1'b1;
      if0.write = 1'b0; if0.writenum = '0; if0.data_in = '0; if0.readnum_a = '0; if0.readnum_b = '0;
      if0.reserve = 1'b0; if0.reservenum = '0;
      if1.write = 1'b0; if1.writenum = '0; if1.data_in = '0; if1.readnum_a = '0; if1.readnum_b = '0;
      if1.reserve = 1'b0; if1.reservenum = '0;
      if2.write = 1'b0; if2.writenum = '0; if2.data_in = '0; if2.readnum_a = '0; if2.readnum_b = '0;
      if2.reserve = 1'b0; if2.reservenum = '0;

      // write wnum din ra rb reserve rnum | exp_a exp_b ba bb ok | vec cnt (after edge)
      tbl[0]  = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
      tbl[1]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
      tbl[2]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 1'b1, 3'd2, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'h04, 4'd1};
      tbl[3]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h04, 4'd1};
      tbl[4]  = '{1'b1, 3'd2, 16'h00AA, 3'd2, 3'd1, 1'b0, 3'd0, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
      tbl[5]  = '{1'b1, 3'd2, 16'h0055, 3'd2, 3'd2, 1'b1, 3'd2, 16'h0055, 16'h0055, 1'b0, 1'b0, 1'b1, 8'h04, 4'd1};
      tbl[6]  = '{1'b1, 3'd2, 16'h0077, 3'd2, 3'd5, 1'b1, 3'd2, 16'h0077, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'h04, 4'd1};
      tbl[7]  = '{1'b1, 3'd2, 16'h0011, 3'd2, 3'd1, 1'b1, 3'd1, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h02, 4'd1};
      tbl[8]  = '{1'b1, 3'd1, 16'h1111, 3'd6, 3'd1, 1'b1, 3'd6, 16'h0000, 16'h1111, 1'b0, 1'b0, 1'b1, 8'h40, 4'd1};
      tbl[9]  = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd2, 1'b1, 3'd6, 16'h0000, 16'h0011, 1'b1, 1'b0, 1'b0, 8'h40, 4'd1};
      tbl[10] = '{1'b1, 3'd7, 16'hABCD, 3'd7, 3'd3, 1'b1, 3'd3, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h48, 4'd2};
      tbl[11] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b1, 3'd0, 16'h0000, 16'hABCD, 1'b0, 1'b0, 1'b1, 8'h49, 4'd3};
      tbl[12] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd3, 1'b0, 3'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h48, 4'd2};
      tbl[13] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 1'b0, 3'd0, 16'hFFFF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h48, 4'd2};

      #1;
      check("rst_data_a", 32'(if0.data_out_a), 32'h0);
      check("rst_vec",    32'(if0.busy_vec),   32'h0);
      check("rst_cnt",    32'(if0.busy_cnt),   32'h0);
      check("rst_cnt6",   32'(if2.busy_cnt),   32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors on the default build.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if0.write      = tbl[i].write;
         if0.writenum   = tbl[i].wnum;
         if0.data_in    = tbl[i].din;
         if0.readnum_a  = tbl[i].ra;
         if0.readnum_b  = tbl[i].rb;
         if0.reserve    = tbl[i].reserve;
         if0.reservenum = tbl[i].rnum;
         #1;
         check($sformatf("v%0d_data_a", i), 32'(if0.data_out_a), 32'(tbl[i].exp_a));
         check($sformatf("v%0d_data_b", i), 32'(if0.data_out_b), 32'(tbl[i].exp_b));
         check($sformatf("v%0d_busy_a", i), 32'(if0.busy_a),     32'(tbl[i].exp_ba));
         check($sformatf("v%0d_busy_b", i), 32'(if0.busy_b),     32'(tbl[i].exp_bb));
         check($sformatf("v%0d_rsv_ok", i), 32'(if0.reserve_ok), 32'(tbl[i].exp_ok));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_vec", i), 32'(if0.busy_vec), 32'(tbl[i].exp_vec));
         check($sformatf("v%0d_cnt", i), 32'(if0.busy_cnt), 32'(tbl[i].exp_cnt));
      end

      // Asynchronous reset between edges clears data and scoreboard at once.
      @(negedge clk);
      if0.write = 1'b0; if0.reserve = 1'b0; if0.readnum_a = 3'd5;
      #1;
      check("pre_rst_a", 32'(if0.data_out_a), 32'hBEEF);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_a",   32'(if0.data_out_a), 32'h0);
      check("async_rst_vec", 32'(if0.busy_vec),   32'h0);
      check("async_rst_cnt", 32'(if0.busy_cnt),   32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_a", 32'(if0.data_out_a), 32'h0);

      // No bypass, hardwired R0.
      @(negedge clk);
      if1.write = 1'b1; if1.writenum = 3'd5; if1.data_in = 16'hBEEF;
      if1.readnum_a = 3'd5; if1.readnum_b = 3'd5;
      #1;
      check("nb_pre_a", 32'(if1.data_out_a), 32'h0);
      check("nb_pre_b", 32'(if1.data_out_b), 32'h0);
      @(posedge clk);
      #1;
      check("nb_post_a", 32'(if1.data_out_a), 32'hBEEF);
      @(negedge clk);
      if1.write = 1'b0; if1.reserve = 1'b1; if1.reservenum = 3'd4; if1.readnum_a = 3'd4;
      #1;
      check("nb_rsv_ok", 32'(if1.reserve_ok), 32'h1);
      @(posedge clk);
      #1;
      check("nb_rsv_vec", 32'(if1.busy_vec), 32'h10);
      check("nb_rsv_ba",  32'(if1.busy_a),   32'h1);
      @(negedge clk);
      if1.reserve = 1'b0; if1.write = 1'b1; if1.writenum = 3'd4; if1.data_in = 16'h4444;
      #1;
      check("nb_wb_pre_ba", 32'(if1.busy_a),     32'h1);
      check("nb_wb_pre_a",  32'(if1.data_out_a), 32'h0);
      @(posedge clk);
      #1;
      check("nb_wb_a",   32'(if1.data_out_a), 32'h4444);
      check("nb_wb_ba",  32'(if1.busy_a),     32'h0);
      check("nb_wb_vec", 32'(if1.busy_vec),   32'h0);
      @(negedge clk);
      if1.write = 1'b1; if1.writenum = 3'd0; if1.data_in = 16'hFFFF;
      if1.reserve = 1'b1; if1.reservenum = 3'd0; if1.readnum_a = 3'd0;
      #1;
      check("z0_rsv_ok", 32'(if1.reserve_ok), 32'h0);
      check("z0_pre_a",  32'(if1.data_out_a), 32'h0);
      @(posedge clk);
      #1;
      check("z0_a",   32'(if1.data_out_a), 32'h0);
      check("z0_ba",  32'(if1.busy_a),     32'h0);
      check("z0_vec", 32'(if1.busy_vec),   32'h0);
      check("z0_cnt", 32'(if1.busy_cnt),   32'h0);
      @(negedge clk);
      if1.write = 1'b0; if1.reserve = 1'b0;

      // DEPTH=6: out-of-range write/read and filling the scoreboard.
      if2.write = 1'b1; if2.writenum = 3'd3; if2.data_in = 16'h3333;
      @(negedge clk);
      if2.writenum = 3'd7; if2.data_in = 16'h1234; if2.readnum_a = 3'd6; if2.readnum_b = 3'd3;
      #1;
      check("d6_oor_a",  32'(if2.data_out_a), 32'h0);
      check("d6_oor_ba", 32'(if2.busy_a),     32'h0);
      check("d6_r3_b",   32'(if2.data_out_b), 32'h3333);
      @(negedge clk);
      if2.write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if2.readnum_a = 3'(i);
         #1;
         check($sformatf("d6_reg%0d", i), 32'(if2.data_out_a), (i == 3) ? 32'h3333 : 32'h0);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if2.reserve = 1'b1; if2.reservenum = 3'(i);
         #1;
         check($sformatf("d6_rsv%0d_ok", i), 32'(if2.reserve_ok), 32'h1);
      end
      @(negedge clk);
      if2.reservenum = 3'd6; if2.readnum_a = 3'd6;
      #1;
      check("d6_full_vec", 32'(if2.busy_vec),   32'h3F);
      check("d6_full_cnt", 32'(if2.busy_cnt),   32'h6);
      check("d6_rsv6_ok",  32'(if2.reserve_ok), 32'h0);
      check("d6_rd6_ba",   32'(if2.busy_a),     32'h0);
      if2.reservenum = 3'd5;
      #1;
      check("d6_rsv5_again", 32'(if2.reserve_ok), 32'h0);
      @(posedge clk);
      #1;
      check("d6_cnt_hold", 32'(if2.busy_cnt), 32'h6);
      @(negedge clk);
      if2.reserve = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
